bus_window_controller: RTL and testbench
========================================

# bus_window_controller

Parametrised, clocked successor to the combinational address decode for the MAXI030 core. It holds NUM_WINDOWS runtime-programmable address windows and registers the device select and port width for each 68030 bus cycle. It generates DSACK itself, with per-window wait states or external pacing, and raises BERR on unmapped accesses or timeout. It also owns the post-reset ROM overlay and produces vector_fetched internally.

## Interface
- NUM_WINDOWS, 8: number of decode windows; device_selected width.
- ADDR_UPPER_WIDTH, 8: compared address bits (A31 downward).
- WAIT_WIDTH, 4: wait-state field width; all-ones means externally paced.
- TIMEOUT_CYCLES, 255: clocks from DECODE to BERR; must be < 2^16.
- BOOT_FETCHES, 4: completed normal cycles served by the ROM overlay after reset.
- ROM_WINDOW, 0: window index forced during overlay.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- as  in  1  address strobe, active high (asserted).
- fc  in  3  function code.
- addr_middle  in  4  A19:A16, CPU-space type.
- addr_upper  in  ADDR_UPPER_WIDTH  upper address bits.
- ext_ack  in  1  device ready, used by externally paced windows.
- cfg_write  in  1  one-clock strobe; loads window cfg_index.
- cfg_index  in  clog2(NUM_WINDOWS)  window to load.
- cfg_base, cfg_mask  in  ADDR_UPPER_WIDTH each  hit when (addr_upper & cfg_mask) == (cfg_base & cfg_mask).
- cfg_width  in  2  port width, `PORT_WIDTH_*` encoding.
- cfg_waits  in  WAIT_WIDTH  wait states.
- cfg_enable  in  1  window enable.
- device_selected  out  NUM_WINDOWS  one-hot registered select.
- port_width  out  2  registered width of the selected window.
- dsack  out  2  active-high: LONG=11, WORD=10, BYTE=01, none=00.
- berr  out  1  bus error.
- int_ack  out  1  interrupt-acknowledge cycle in progress.
- vector_fetched  out  1  overlay finished.

## Operation
- Window registers reset to disabled, with base/mask/width/waits cleared. A cfg_write takes effect on the following clock and never alters the selection already latched for the cycle in flight.
- Hit: window enabled and the masked compare matches. On multiple hits, the lowest index wins.
- CPU-space cycles (fc=3'b111):
  - No window is selected, no dsack is driven, and the timeout is disabled.
  - int_ack=1 for the duration of the cycle when addr_middle=4'hf.
  - Completion belongs to external logic.
- Overlay: while vector_fetched=0, every normal cycle selects ROM_WINDOW using its programmed width and waits, or WORD and 0 waits if that window is disabled. An 8-bit counter counts cycles ending in ACK. When it reaches BOOT_FETCHES, vector_fetched is set to 1 and stays set until reset.
- FSM states:
  - IDLE: when as=1 and fc≠7, go to DECODE.
  - DECODE: latch outputs and load the wait counter.
    - No hit: go to BERR.
    - waits=0: go to ACK.
    - Otherwise: go to WAIT.
  - WAIT: decrement the counter and go to ACK when it reaches 1. If waits is all-ones, hold until ext_ack=1, then go to ACK.
  - ACK: drive dsack from port_width and hold until as=0.
  - BERR: berr=1 and hold until as=0.
- Timeout: a 16-bit counter is cleared in DECODE and increments in WAIT. When it reaches TIMEOUT_CYCLES, go to BERR; timeout takes priority over a same-cycle ext_ack.
- as=0 in any non-IDLE state returns the FSM to IDLE. An aborted cycle does not count toward the overlay.
- Reset values:
  - All outputs are 0, including dsack=00 and vector_fetched=0.
  - FSM is IDLE and the overlay counter is 0.
  - All windows are disabled.

## Timing
- Clock numbering: as is first sampled high at edge 0.
  - device_selected and port_width are valid after edge 1.
  - dsack asserts after edge 2+waits.
  - berr for an unmapped address asserts after edge 2.
- External pacing: dsack asserts 1 clock after ext_ack is sampled high.
- Cycle end: all outputs clear 1 clock after as=0 is sampled.
- Back-to-back cycles: as must be sampled low for at least 1 clock between cycles.
- Reset: asynchronous assertion mid-cycle clears outputs immediately, with no glitch on dsack or berr.
- int_ack is combinational from as/fc/addr_middle and registered once; it is valid 1 clock after the edge.

## Test plan
- Reset, then 4 normal cycles at addr_upper=8'h40 with window 0 programmed WORD, waits 0 -> each selects window 0, dsack=10 at edge 2, vector_fetched=1 after the 4th ACK; the 5th cycle decodes normally.
- Window 3: base 8'hd0, mask 8'hff, LONG, waits 3; access 8'hd0 -> device_selected=8'b00001000, dsack=11 at edge 5.
- Windows 1 and 5 both match 8'h90 -> window 1 selected; window 1 disabled by cfg_write -> window 5 selected on the next cycle.
- Unmapped 8'h7f -> berr at edge 2, dsack=00; as drop -> berr=0 one clock later.
- Externally paced window: ext_ack held low -> berr at DECODE+255; repeat with ext_ack at clock 10 -> dsack at clock 11, no berr.
- fc=7, addr_middle=f -> int_ack=1, no select, no dsack, no berr for 1000 clocks; reset_n pulsed mid-WAIT -> all outputs 0, vector_fetched=0.

Source files
------------

// File: rtl/bus_window_controller.sv
// bus_window_controller: clocked 68030 address decode with programmable windows, DSACK/BERR generation and boot ROM overlay
//   clock, reset_n          : system clock, asynchronous active-low reset
//   as, fc, addr_middle     : 68030 strobe, function code, A19:A16
//   addr_upper              : upper address bits compared against the windows
//   ext_ack                 : device ready for externally paced windows
//   cfg_*                   : one-clock window programming strobe and fields
//   device_selected         : registered one-hot window select
//   port_width              : registered port width of the selected window
//   dsack, berr             : registered cycle termination
//   int_ack                 : registered interrupt-acknowledge indication
//   vector_fetched          : boot ROM overlay finished
module bus_window_controller #(
  parameter int NUM_WINDOWS      = 8,
  parameter int ADDR_UPPER_WIDTH = 8,
  parameter int WAIT_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int BOOT_FETCHES     = 4,
  parameter int ROM_WINDOW       = 0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             as,
  input  logic [2:0]                       fc,
  input  logic [3:0]                       addr_middle,
  input  logic [ADDR_UPPER_WIDTH-1:0]      addr_upper,
  input  logic                             ext_ack,
  input  logic                             cfg_write,
  input  logic [$clog2(NUM_WINDOWS)-1:0]   cfg_index,
  input  logic [ADDR_UPPER_WIDTH-1:0]      cfg_base,
  input  logic [ADDR_UPPER_WIDTH-1:0]      cfg_mask,
  input  logic [1:0]                       cfg_width,
  input  logic [WAIT_WIDTH-1:0]            cfg_waits,
  input  logic                             cfg_enable,
  output logic [NUM_WINDOWS-1:0]           device_selected,
  output logic [1:0]                       port_width,
  output logic [1:0]                       dsack,
  output logic                             berr,
  output logic                             int_ack,
  output logic                             vector_fetched
);
  localparam int IW = $clog2(NUM_WINDOWS);
  localparam logic [IW-1:0] ROM_IDX = IW'(ROM_WINDOW);
  localparam logic [1:0] PORT_WIDTH_WORD = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_BERR} state_t;
  state_t state, state_next;
  logic [NUM_WINDOWS-1:0][ADDR_UPPER_WIDTH-1:0] win_base, win_mask;
  logic [NUM_WINDOWS-1:0][1:0] win_width;
  logic [NUM_WINDOWS-1:0][WAIT_WIDTH-1:0] win_waits;
  logic [NUM_WINDOWS-1:0] win_en;
  logic [IW-1:0] sel_idx;
  logic sel_hit;
  logic [1:0] sel_width;
  logic [WAIT_WIDTH-1:0] sel_waits;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic ext_paced;
  logic [15:0] time_cnt;
  logic [7:0] boot_cnt;
  logic timeout, wait_done;
  // Lowest matching index wins; during the overlay every cycle is forced to the ROM window,
  // falling back to WORD with no waits while that window is still unprogrammed.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_WINDOWS - 1; i >= 0; i--)
      if (win_en[i] && ((addr_upper ^ win_base[i]) & win_mask[i]) == '0) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
      end
    if (!vector_fetched) begin
      sel_hit = 1'b1;
      sel_idx = ROM_IDX;
    end
    sel_width = (vector_fetched || win_en[sel_idx]) ? win_width[sel_idx] : PORT_WIDTH_WORD;
    sel_waits = (vector_fetched || win_en[sel_idx]) ? win_waits[sel_idx] : '0;
  end
  // time_cnt starts at 0 on the DECODE edge, so adding 2 counts the DECODE clock and the
  // clock being left: berr lands TIMEOUT_CYCLES clocks after the DECODE edge.
  assign timeout = 17'(time_cnt) + 17'd2 >= 17'(TIMEOUT_CYCLES);
  assign wait_done = ext_paced ? ext_ack : wait_cnt == WAIT_WIDTH'(1);
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = (as && fc != 3'b111) ? S_DECODE : S_IDLE;
      S_DECODE: state_next = !as ? S_IDLE : !sel_hit ? S_BERR : sel_waits == '0 ? S_ACK : S_WAIT;
      S_WAIT:   state_next = !as ? S_IDLE : timeout ? S_BERR : wait_done ? S_ACK : S_WAIT;
      S_ACK:    state_next = as ? S_ACK : S_IDLE;
      S_BERR:   state_next = as ? S_BERR : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_next;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      win_base <= '0;
      win_mask <= '0;
      win_width <= '0;
      win_waits <= '0;
      win_en <= '0;
    end else if (cfg_write) begin
      win_base[cfg_index] <= cfg_base;
      win_mask[cfg_index] <= cfg_mask;
      win_width[cfg_index] <= cfg_width;
      win_waits[cfg_index] <= cfg_waits;
      win_en[cfg_index] <= cfg_enable;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      device_selected <= '0;
      port_width <= '0;
      dsack <= '0;
      berr <= 1'b0;
      int_ack <= 1'b0;
      vector_fetched <= 1'b0;
      boot_cnt <= '0;
      wait_cnt <= '0;
      ext_paced <= 1'b0;
      time_cnt <= '0;
    end else begin
      int_ack <= as && fc == 3'b111 && addr_middle == 4'hf;
      dsack <= (state == S_ACK && as) ? port_width : 2'b00;
      berr <= state == S_BERR && as;
      if (!as) begin
        device_selected <= '0;
        port_width <= '0;
      end else if (state == S_DECODE) begin
        device_selected <= sel_hit ? NUM_WINDOWS'(1) << sel_idx : '0;
        port_width <= sel_hit ? sel_width : 2'b00;
        wait_cnt <= sel_waits;
        ext_paced <= &sel_waits;
        time_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= ext_paced ? wait_cnt : wait_cnt - WAIT_WIDTH'(1);
        time_cnt <= time_cnt + 16'd1;
      end
      if (state == S_ACK && !as && !vector_fetched) begin
        boot_cnt <= boot_cnt + 8'd1;
        vector_fetched <= boot_cnt + 8'd1 >= 8'(BOOT_FETCHES);
      end
    end
endmodule

// File: tb/tb_bus_window_controller.sv
// tb_bus_window_controller: directed-vector bench for bus_window_controller
module tb_bus_window_controller;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic as = 1'b0;
  logic [2:0] fc = 3'b101;
  logic [3:0] addr_middle = 4'h0;
  logic [7:0] addr_upper = 8'h00;
  logic ext_ack = 1'b0;
  logic cfg_write = 1'b0;
  logic [2:0] cfg_index = '0;
  logic [7:0] cfg_base = '0, cfg_mask = '0;
  logic [1:0] cfg_width = '0;
  logic [3:0] cfg_waits = '0;
  logic cfg_enable = 1'b0;
  logic [7:0] device_selected;
  logic [1:0] port_width, dsack;
  logic berr, int_ack, vector_fetched;
  int vectors = 0;
  int miscompares = 0;
  bus_window_controller dut (
    .clock(clock), .reset_n(reset_n), .as(as), .fc(fc), .addr_middle(addr_middle),
    .addr_upper(addr_upper), .ext_ack(ext_ack), .cfg_write(cfg_write), .cfg_index(cfg_index),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_width(cfg_width), .cfg_waits(cfg_waits),
    .cfg_enable(cfg_enable), .device_selected(device_selected), .port_width(port_width),
    .dsack(dsack), .berr(berr), .int_ack(int_ack), .vector_fetched(vector_fetched)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic cfg(input logic [2:0] idx, input logic [7:0] base, input logic [7:0] mask,
                     input logic [1:0] width, input logic [3:0] waits, input logic en);
    cfg_index = idx; cfg_base = base; cfg_mask = mask;
    cfg_width = width; cfg_waits = waits; cfg_enable = en;
    cfg_write = 1'b1;
    tick();
    cfg_write = 1'b0;
  endtask
  task automatic start(input logic [7:0] a);
    fc = 3'b101;
    addr_upper = a;
    as = 1'b1;
    tick();
  endtask
  task automatic finish_cycle();
    as = 1'b0;
    tick();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic ok;
    tick();
    tick();
    check("rst_sel", 16'(device_selected), 16'h00);
    check("rst_pw", 16'(port_width), 16'h0);
    check("rst_dsack", 16'(dsack), 16'h0);
    check("rst_berr", 16'(berr), 16'h0);
    check("rst_int_ack", 16'(int_ack), 16'h0);
    check("rst_vf", 16'(vector_fetched), 16'h0);
    reset_n = 1'b1;
    tick();
    cfg(3'd0, 8'h40, 8'hff, 2'b10, 4'd0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      start(8'h40);
      tick();
      check("boot_sel", 16'(device_selected), 16'h01);
      check("boot_pw", 16'(port_width), 16'h2);
      check("boot_dsack_e1", 16'(dsack), 16'h0);
      tick();
      check("boot_dsack_e2", 16'(dsack), 16'h2);
      finish_cycle();
      check("boot_end_dsack", 16'(dsack), 16'h0);
      check("boot_end_sel", 16'(device_selected), 16'h00);
      check("boot_vf", 16'(vector_fetched), (n >= 4) ? 16'h1 : 16'h0);
    end
    start(8'h7f);
    tick();
    check("unmap_sel", 16'(device_selected), 16'h00);
    check("unmap_berr_e1", 16'(berr), 16'h0);
    tick();
    check("unmap_berr_e2", 16'(berr), 16'h1);
    check("unmap_dsack", 16'(dsack), 16'h0);
    finish_cycle();
    check("unmap_berr_end", 16'(berr), 16'h0);
    cfg(3'd3, 8'hd0, 8'hff, 2'b11, 4'd3, 1'b1);
    start(8'hd0);
    tick();
    check("w3_sel", 16'(device_selected), 16'h08);
    check("w3_pw", 16'(port_width), 16'h3);
    tick(); tick(); tick();
    check("w3_dsack_e4", 16'(dsack), 16'h0);
    tick();
    check("w3_dsack_e5", 16'(dsack), 16'h3);
    finish_cycle();
    check("w3_end", 16'(dsack), 16'h0);
    cfg(3'd1, 8'h90, 8'hf0, 2'b01, 4'd0, 1'b1);
    cfg(3'd5, 8'h80, 8'hc0, 2'b10, 4'd0, 1'b1);
    start(8'h90);
    tick();
    check("prio_sel", 16'(device_selected), 16'h02);
    check("prio_pw", 16'(port_width), 16'h1);
    tick();
    check("prio_dsack", 16'(dsack), 16'h1);
    finish_cycle();
    cfg(3'd1, 8'h90, 8'hf0, 2'b01, 4'd0, 1'b0);
    start(8'h90);
    tick();
    check("w5_sel", 16'(device_selected), 16'h20);
    cfg(3'd5, 8'h80, 8'hc0, 2'b10, 4'd0, 1'b0);
    check("w5_sel_after_cfg", 16'(device_selected), 16'h20);
    check("w5_dsack", 16'(dsack), 16'h2);
    finish_cycle();
    start(8'h90);
    tick();
    tick();
    check("all_off_berr", 16'(berr), 16'h1);
    finish_cycle();
    cfg(3'd2, 8'ha0, 8'hff, 2'b11, 4'hf, 1'b1);
    ext_ack = 1'b0;
    start(8'ha0);
    tick();
    check("ext_sel", 16'(device_selected), 16'h04);
    for (int e = 2; e <= 255; e++) tick();
    check("to_berr_e255", 16'(berr), 16'h0);
    tick();
    check("to_berr_e256", 16'(berr), 16'h1);
    check("to_dsack", 16'(dsack), 16'h0);
    finish_cycle();
    check("to_berr_end", 16'(berr), 16'h0);
    start(8'ha0);
    for (int e = 1; e <= 9; e++) tick();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    check("ext_dsack_e10", 16'(dsack), 16'h0);
    tick();
    check("ext_dsack_e11", 16'(dsack), 16'h3);
    check("ext_berr", 16'(berr), 16'h0);
    finish_cycle();
    start(8'ha0);
    for (int e = 1; e <= 254; e++) tick();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    tick();
    check("to_prio_berr", 16'(berr), 16'h1);
    check("to_prio_dsack", 16'(dsack), 16'h0);
    finish_cycle();
    fc = 3'b111;
    addr_middle = 4'hf;
    addr_upper = 8'h40;
    as = 1'b1;
    tick();
    check("iack_on", 16'(int_ack), 16'h1);
    ok = 1'b1;
    for (int e = 0; e < 1000; e++) begin
      tick();
      if (int_ack !== 1'b1 || device_selected !== 8'h00 || dsack !== 2'b00 || berr !== 1'b0) ok = 1'b0;
    end
    check("iack_quiet_1000", 16'(ok), 16'h1);
    as = 1'b0;
    tick();
    check("iack_off", 16'(int_ack), 16'h0);
    addr_middle = 4'h0;
    start(8'hd0);
    tick();
    tick();
    check("mid_wait_sel", 16'(device_selected), 16'h08);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sel", 16'(device_selected), 16'h00);
    check("arst_pw", 16'(port_width), 16'h0);
    check("arst_dsack", 16'(dsack), 16'h0);
    check("arst_berr", 16'(berr), 16'h0);
    check("arst_vf", 16'(vector_fetched), 16'h0);
    as = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    start(8'h7f);
    tick();
    check("ovl_default_sel", 16'(device_selected), 16'h01);
    check("ovl_default_pw", 16'(port_width), 16'h2);
    tick();
    check("ovl_default_dsack", 16'(dsack), 16'h2);
    finish_cycle();
    check("ovl_default_vf", 16'(vector_fetched), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
